// File: rtl/pwm_multi_ch_if.sv
// ---------------------------------------------------------------------------
// pwm_multi_ch_if
//
// Purpose: duty-write bus for pwm_multi_ch. One single-cycle write strobe
// carries a channel index and a duty value.
//
// Signals:
//   duty_wr    single-cycle write strobe
//   duty_sel   channel index (SEL_W bits, at least 1)
//   duty_data  duty value (WIDTH bits)
//
// Modports:
//   master  drives the write (host / testbench side)
//   slave   receives the write (PWM block side)
// ---------------------------------------------------------------------------
interface pwm_multi_ch_if #(
    parameter int CH    = 4,
    parameter int WIDTH = 8,
    parameter int SEL_W = (CH > 1) ? $clog2(CH) : 1
);
    logic             duty_wr;
    logic [SEL_W-1:0] duty_sel;
    logic [WIDTH-1:0] duty_data;

    modport master (output duty_wr, output duty_sel, output duty_data);
    modport slave  (input  duty_wr, input  duty_sel, input  duty_data);
endinterface

// File: rtl/pwm_multi_ch.sv
// ---------------------------------------------------------------------------
// pwm_multi_ch
//
// Purpose: CH independent PWM channels sharing one prescaler and one main
// counter. The counter runs edge-aligned (0..MAX, wrap) or center-aligned
// (0..MAX..1, 2*MAX steps). Each channel output is high while the counter is
// below the channel duty, forced high for duty == MAX.
//
// Optional feature: define PWM_SHADOW_EN to add a per-channel pending duty
// register. Writes then land in pending and are copied to the active duty at
// each period boundary (or go straight to active while disabled or when the
// write coincides with a boundary). Without the macro, writes update the
// active duty immediately and no pending registers exist.
//
// Ports:
//   clk          clock, all state on rising edge
//   rst_n        asynchronous active-low reset
//   en           run enable; low holds counters at 0 and outputs low
//   div          prescaler terminal value, one counter step every div+1 clocks
//   center_mode  0 = edge-aligned, 1 = center-aligned (sampled at boundary)
//   duty_bus     duty write bus (slave modport)
//   pwm_out      registered PWM outputs, bit i = channel i
//   period_tick  one-clock pulse when the counter steps to 0
// ---------------------------------------------------------------------------
module pwm_multi_ch #(
    parameter int CH    = 4,
    parameter int WIDTH = 8,
    parameter int DIV_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [DIV_W-1:0]   div,
    input  logic               center_mode,
    pwm_multi_ch_if.slave      duty_bus,
    output logic [CH-1:0]      pwm_out,
    output logic               period_tick
);

    localparam int SEL_W = (CH > 1) ? $clog2(CH) : 1;
    localparam logic [WIDTH-1:0] MAX = '1;

    logic [DIV_W-1:0] presc_q, presc_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;      // 0 = counting up, 1 = counting down
    logic             mode_q, mode_d;    // center_mode latched for the current period
    logic             tick_q, tick_d;
    logic [CH-1:0]    pwm_q, pwm_d;
    logic [WIDTH-1:0] duty_q [CH];
    logic [WIDTH-1:0] duty_d [CH];
`ifdef PWM_SHADOW_EN
    logic [WIDTH-1:0] pend_q [CH];
    logic [WIDTH-1:0] pend_d [CH];
`endif

    logic step;
    logic boundary;

    // Prescaler, main counter, direction and mode latch.
    always_comb begin
        presc_d  = presc_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        mode_d   = mode_q;
        step     = 1'b0;
        boundary = 1'b0;
        if (!en) begin
            // Idle: the counter sits at the start of a period, so the mode
            // for the first period after enable is taken from the live input.
            presc_d = '0;
            cnt_d   = '0;
            dir_d   = 1'b0;
            mode_d  = center_mode;
        end else begin
            // >= rather than == so that lowering div below the current
            // count produces a step on the very next clock.
            if (presc_q >= div) begin
                step    = 1'b1;
                presc_d = '0;
            end else begin
                presc_d = presc_q + 1'b1;
            end

            if (step) begin
                if (!mode_q) begin
                    if (cnt_q == MAX) begin
                        cnt_d    = '0;
                        boundary = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (!dir_q) begin
                    if (cnt_q == MAX) begin
                        cnt_d = MAX - 1'b1;
                        dir_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    if (cnt_q <= WIDTH'(1)) begin
                        cnt_d    = '0;
                        dir_d    = 1'b0;
                        boundary = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                if (boundary) begin
                    mode_d = center_mode;
                end
            end
        end
        tick_d = boundary;
    end

    // Duty registers and per-channel compare.
    always_comb begin
        pwm_d = '0;
        for (int i = 0; i < CH; i++) begin
            duty_d[i] = duty_q[i];
`ifdef PWM_SHADOW_EN
            pend_d[i] = pend_q[i];
            if (boundary) begin
                duty_d[i] = pend_q[i];
            end
            if (duty_bus.duty_wr && (duty_bus.duty_sel == SEL_W'(i))) begin
                pend_d[i] = duty_bus.duty_data;
                if (!en || boundary) begin
                    duty_d[i] = duty_bus.duty_data;
                end
            end
`else
            if (duty_bus.duty_wr && (duty_bus.duty_sel == SEL_W'(i))) begin
                duty_d[i] = duty_bus.duty_data;
            end
`endif
            // Indices >= CH never match, so such writes fall through untouched.
            pwm_d[i] = en && ((duty_q[i] == MAX) || (cnt_q < duty_q[i]));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            mode_q  <= 1'b0;
            tick_q  <= 1'b0;
            pwm_q   <= '0;
            for (int i = 0; i < CH; i++) begin
                duty_q[i] <= '0;
`ifdef PWM_SHADOW_EN
                pend_q[i] <= '0;
`endif
            end
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
            tick_q  <= tick_d;
            pwm_q   <= pwm_d;
            for (int i = 0; i < CH; i++) begin
                duty_q[i] <= duty_d[i];
`ifdef PWM_SHADOW_EN
                pend_q[i] <= pend_d[i];
`endif
            end
        end
    end

    assign pwm_out     = pwm_q;
    assign period_tick = tick_q;

endmodule

// File: tb/tb_pwm_multi_ch.sv
// ---------------------------------------------------------------------------
// tb_pwm_multi_ch
//
// Scoreboard bench for pwm_multi_ch (CH=4, WIDTH=8, DIV_W=3). The stimulus
// process pushes one expected record per PWM period it expects (period
// length in clocks and high-clock count per channel); the monitor measures
// every period between two period_tick pulses and pops/compares a record
// whenever one is queued. A second instance with CH=3 covers writes to a
// channel index that does not exist.
// ---------------------------------------------------------------------------
module tb_pwm_multi_ch;
    localparam int CH    = 4;
    localparam int WIDTH = 8;
    localparam int DIV_W = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic             center_mode = 1'b0;
    logic [DIV_W-1:0] div = '0;
    logic [CH-1:0]    pwm_out;
    logic             period_tick;

    logic             en3 = 1'b0;
    logic             center3 = 1'b0;
    logic [DIV_W-1:0] div3 = '0;
    logic [2:0]       pwm_out3;
    logic             tick3;

    pwm_multi_ch_if #(.CH(CH), .WIDTH(WIDTH)) bus ();
    pwm_multi_ch_if #(.CH(3),  .WIDTH(WIDTH)) bus3 ();

    pwm_multi_ch #(.CH(CH), .WIDTH(WIDTH), .DIV_W(DIV_W)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .div         (div),
        .center_mode (center_mode),
        .duty_bus    (bus),
        .pwm_out     (pwm_out),
        .period_tick (period_tick)
    );

    pwm_multi_ch #(.CH(3), .WIDTH(WIDTH), .DIV_W(DIV_W)) u_dut3 (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en3),
        .div         (div3),
        .center_mode (center3),
        .duty_bus    (bus3),
        .pwm_out     (pwm_out3),
        .period_tick (tick3)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0]          len;
        logic [CH-1:0][15:0]  hi;
    } rec_t;

    rec_t exp_q [$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic void check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    function automatic rec_t mk(input int len, input int h0, input int h1,
                                input int h2, input int h3);
        rec_t r;
        r.len   = 16'(len);
        r.hi[0] = 16'(h0);
        r.hi[1] = 16'(h1);
        r.hi[2] = 16'(h2);
        r.hi[3] = 16'(h3);
        return r;
    endfunction

    // Monitor: measure each full period (sample after one tick through the
    // next tick) and compare with the oldest queued expectation.
    int mon_len;
    int mon_hi [CH];
    bit have_start;

    initial begin
        rec_t r;
        have_start = 1'b0;
        mon_len = 0;
        for (int i = 0; i < CH; i++) mon_hi[i] = 0;
        forever begin
            @(negedge clk);
            if (!rst_n || !en) begin
                have_start = 1'b0;
                mon_len = 0;
                for (int i = 0; i < CH; i++) mon_hi[i] = 0;
            end else begin
                mon_len++;
                for (int i = 0; i < CH; i++) mon_hi[i] += int'(pwm_out[i]);
                if (period_tick) begin
                    if (have_start && (exp_q.size() > 0)) begin
                        r = exp_q.pop_front();
                        check("period_len", mon_len, int'(r.len));
                        for (int i = 0; i < CH; i++)
                            check($sformatf("high_clocks_ch%0d", i), mon_hi[i], int'(r.hi[i]));
                    end
                    have_start = 1'b1;
                    mon_len = 0;
                    for (int i = 0; i < CH; i++) mon_hi[i] = 0;
                end
            end
        end
    end

    task automatic wr(input int sel, input int data);
        @(negedge clk);
        bus.duty_wr   = 1'b1;
        bus.duty_sel  = 2'(sel);
        bus.duty_data = 8'(data);
        @(negedge clk);
        bus.duty_wr   = 1'b0;
    endtask

    task automatic wr3(input int sel, input int data);
        @(negedge clk);
        bus3.duty_wr   = 1'b1;
        bus3.duty_sel  = 2'(sel);
        bus3.duty_data = 8'(data);
        @(negedge clk);
        bus3.duty_wr   = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_q.size() > 0) && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() > 0) begin
            check("scoreboard_drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic wait_tick(input int budget);
        int n = 0;
        bit seen = 1'b0;
        while (!seen && (n < budget)) begin
            @(negedge clk);
            n++;
            seen = period_tick;
        end
        if (!seen) check("period_tick_timeout", 0, 1);
    endtask

    initial begin
        logic [CH-1:0] acc;
        logic          tacc;
        logic [2:0]    acc3;
        int            n;
        bit            seen;

        bus.duty_wr = 1'b0;  bus.duty_sel = '0;  bus.duty_data = '0;
        bus3.duty_wr = 1'b0; bus3.duty_sel = '0; bus3.duty_data = '0;

        // Reset state
        #23;
        check("reset_pwm_out", int'(pwm_out), 0);
        check("reset_period_tick", int'(period_tick), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Disabled: duties load, outputs stay idle
        wr(0, 64); wr(1, 0); wr(2, 255); wr(3, 128);
        acc = '0; tacc = 1'b0;
        repeat (20) begin
            @(negedge clk);
            acc  |= pwm_out;
            tacc |= period_tick;
        end
        check("disabled_pwm_out", int'(acc), 0);
        check("disabled_period_tick", int'(tacc), 0);

        // Edge mode, div=0
        repeat (3) exp_q.push_back(mk(256, 64, 0, 256, 128));
        @(negedge clk);
        en = 1'b1;
        wait_drain(2000);

        // Center mode, div=1, ch0 duty 100
        @(negedge clk);
        en = 1'b0;
        wr(0, 100);
        center_mode = 1'b1;
        div = 3'd1;
        repeat (2) exp_q.push_back(mk(1020, 398, 0, 1020, 510));
        @(negedge clk);
        en = 1'b1;
        wait_drain(4000);

        // Mid-period mode change takes effect on the following period
        wait_tick(2000);
        repeat (100) @(negedge clk);
        exp_q.push_back(mk(1020, 398, 0, 1020, 510));
        center_mode = 1'b0;
        exp_q.push_back(mk(512, 200, 0, 512, 256));
        wait_drain(3000);

        // Mid-period write of 200 to ch3 (edge mode, div=1)
        wait_tick(1000);
        repeat (100) @(negedge clk);
`ifdef PWM_SHADOW_EN
        exp_q.push_back(mk(512, 200, 0, 512, 256));
`else
        exp_q.push_back(mk(512, 200, 0, 512, 400));
`endif
        exp_q.push_back(mk(512, 200, 0, 512, 400));
        bus.duty_wr   = 1'b1;
        bus.duty_sel  = 2'd3;
        bus.duty_data = 8'd200;
        @(negedge clk);
        bus.duty_wr   = 1'b0;
        wait_drain(1500);

        // div lowered 7 -> 2 while the prescaler is at 4: step on next clock
        @(negedge clk);
        en = 1'b0;
        wr(0, 1);
        div = 3'd7;
        @(negedge clk);
        en = 1'b1;
        repeat (4) @(negedge clk);
        check("div7_count0_pwm0", int'(pwm_out[0]), 1);
        div = 3'd2;
        @(negedge clk);
        check("div_lower_last_count0", int'(pwm_out[0]), 1);
        @(negedge clk);
        check("div_lower_step_next_clock", int'(pwm_out[0]), 0);

        // Asynchronous reset mid-period, then restart from 0
        @(negedge clk);
        en = 1'b0;
        div = 3'd0;
        @(negedge clk);
        en = 1'b1;
        repeat (60) @(negedge clk);
        check("pre_reset_ch2_high", int'(pwm_out[2]), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_pwm_out", int'(pwm_out), 0);
        check("async_reset_period_tick", int'(period_tick), 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        n = 0;
        seen = 1'b0;
        while (!seen && (n < 600)) begin
            @(negedge clk);
            n++;
            seen = period_tick;
        end
        check("restart_clocks_to_first_tick", n, 256);
        check("restart_duties_cleared", int'(pwm_out), 0);

        // CH=3 instance: index 3 does not exist and must be ignored
        @(negedge clk);
        en = 1'b0;
        wr3(3, 255);
        @(negedge clk);
        en3 = 1'b1;
        acc3 = '0;
        repeat (300) begin
            @(negedge clk);
            acc3 |= pwm_out3;
        end
        check("sel_out_of_range_ignored", int'(acc3), 0);
        @(negedge clk);
        en3 = 1'b0;
        wr3(2, 255);
        @(negedge clk);
        en3 = 1'b1;
        repeat (3) @(negedge clk);
        check("sel_in_range_applied", int'(pwm_out3), 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
